subpel_sequencer: RTL
=====================

# subpel_sequencer

Control sequencer for the 8-wide HEVC sub-pixel interpolation datapath. It accepts one block-start request, pulls the (NUM_PIXEL+TAPS-1) input rows from upstream with a valid/ready handshake, and drives the datapath control strobes:

- input shift-register load;
- input-mux select for horizontal and then vertical passes;
- horizontal half-pel shift-register load;
- output-filler load and index.

All strobes are aligned to the FIR pipeline latency. The block sits between the frame fetch logic and the interpolation datapath and replaces its free-running counter control.

## Interface
- NUM_PIXEL, 8, output pixels per row/column of a block
- TAPS, 8, FIR tap count; ROWS = NUM_PIXEL+TAPS-1 = 15
- PIPE_LAT, 2, cycles from mux_sel change to valid FIR output
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request a block; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted through DONE
- done  out  1  one-cycle pulse in DONE
- row_valid  in  1  upstream row available on datapath input
- row_ready  out  1  high only in FILL
- load_in  out  1  = row_valid & row_ready (combinational); shifts input register
- mux_sel  out  8  input-mux select (encoding below)
- load_L  out  1  load horizontal half-pel shift registers (A/B/C)
- load_out  out  1  write FIR outputs into output fillers
- out_idx  out  8  filler slot for current load_out

## Operation
- States: IDLE → FILL → HORIZ → VERT → DRAIN → DONE → IDLE.
- IDLE: start=1 → FILL, clear counters. start in any other state is ignored, including DONE.
- FILL: row_ready=1. Each handshake increments row_cnt. At row_cnt reaching ROWS-1 with a handshake → HORIZ. row_valid=0 holds state and count.
- HORIZ: mux_sel = h_cnt, for 0..ROWS-1, one per cycle, no stall → VERT after h_cnt=ROWS-1.
- VERT: 3*NUM_PIXEL issues.
  - mux_sel = 8'h80 | {src[1:0], col[4:0]}.
  - src: 0=A, 1=B, 2=C.
  - col runs 0..NUM_PIXEL-1 inner, src outer.
  - → DRAIN after the last issue.
- DRAIN: PIPE_LAT cycles, mux_sel held at last value → DONE.
- DONE: done=1 for one cycle → IDLE.
- Issue delay line: PIPE_LAT-deep shift of {is_horiz, is_vert, idx}.
  - load_L = delayed is_horiz.
  - load_out = delayed is_vert, or delayed is_horiz with row in TAPS/2-1 .. TAPS/2+NUM_PIXEL-2 (rows 3..10).
  - out_idx = row-(TAPS/2-1) for horizontal; the VERT encoding for vertical.
- mux_sel outside HORIZ/VERT/DRAIN = 0.

## Timing
- Reset: state=IDLE. busy, done, row_ready, load_in, load_L, load_out = 0. mux_sel=0, out_idx=0. Delay line cleared. Reset mid-block aborts immediately; no done pulse.
- No-stall block, start sampled at cycle 0:
  - FILL cycles 1–15;
  - HORIZ 16–30;
  - VERT 31–54;
  - DRAIN 55–56;
  - done at 57;
  - start accepted again at 58 earliest.
- load_L high cycles 18–32. load_out high 21–28 (out_idx 0..7), then 33–56 (out_idx 8'h80..8'hC7 pattern).
- Each FILL stall cycle delays all later events by exactly one cycle.
- row_valid outside FILL: no effect; load_in stays 0.
- Counter widths: 8 bits. No wrap within a block; all counters reset on entering FILL.

## Configuration
- SUBPEL_PERF_CNT_EN defined:
  - adds output stall_cnt [15:0], counting FILL cycles with row_valid=0;
  - saturates at 16'hFFFF;
  - cleared on rst and on start acceptance;
  - holds value after done.
- Undefined: port and logic absent; all other behaviour identical.

## Structure
- Shared package subpel_pkg:
  - state enum (IDLE, FILL, HORIZ, VERT, DRAIN, DONE);
  - SEL_VERT_FLAG=8'h80;
  - SRC_A/B/C codes;
  - ROWS derivation function.
- One sub-module: subpel_issue_delay, a parameterised PIPE_LAT-deep valid/index shift line with synchronous clear.

## Test plan
- Reset then idle: all outputs 0 for 10 cycles with row_valid=1 and start=0.
- Single block, row_valid always 1, start at cycle 0:
  - 15 load_in pulses;
  - load_L 18–32;
  - load_out 21–28 and 33–56;
  - done at 57 only.
- FILL stalls: row_valid low on 3 cycles mid-FILL → done at 60, and stall_cnt=3 when SUBPEL_PERF_CNT_EN is defined.
- start held high continuously: blocks back-to-back, each done 58 cycles apart; start during busy never restarts.
- rst asserted at cycle 40 (in VERT): next cycle all outputs 0, no done. A new start at 45 yields done at 45+57.
- VERT encoding check: mux_sel sequence 8'h80..8'h87, 8'hA0..8'hA7, 8'hC0..8'hC7. out_idx matches 2 cycles later.

Source files
------------

// File: rtl/subpel_pkg.sv
// subpel_pkg: shared state encoding, mux-select constants and row-count helper for the sub-pel sequencer
package subpel_pkg;

    typedef enum logic [2:0] {IDLE, FILL, HORIZ, VERT, DRAIN, DONE} state_t;

    localparam logic [7:0] SEL_VERT_FLAG = 8'h80;
    localparam logic [1:0] SRC_A = 2'd0;
    localparam logic [1:0] SRC_B = 2'd1;
    localparam logic [1:0] SRC_C = 2'd2;

    function automatic int subpel_rows(input int num_pixel, input int taps);
        return num_pixel + taps - 1;
    endfunction

endpackage

// File: rtl/subpel_issue_delay.sv
// subpel_issue_delay: DEPTH-stage shift line carrying issue flags and index to the FIR output side
module subpel_issue_delay #(
    parameter int DEPTH = 2,
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] line [DEPTH];

    // advance one stage per cycle; reset empties every stage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) line[i] <= '0;
        end else begin
            line[0] <= d;
            for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
        end
    end

    assign q = line[DEPTH-1];

endmodule

// File: rtl/subpel_sequencer.sv
// subpel_sequencer: block control for the 8-wide sub-pel interpolator; SUBPEL_PERF_CNT_EN adds the stall_cnt output
module subpel_sequencer
    import subpel_pkg::*;
#(
    parameter int NUM_PIXEL = 8,
    parameter int TAPS = 8,
    parameter int PIPE_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    input  logic       row_valid,
    output logic       row_ready,
    output logic       load_in,
    output logic [7:0] mux_sel,
    output logic       load_L,
    output logic       load_out,
    output logic [7:0] out_idx
`ifdef SUBPEL_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int ROWS = subpel_rows(NUM_PIXEL, TAPS);
    localparam logic [7:0] ROW_LAST = 8'(ROWS - 1);
    localparam logic [7:0] H_LO = 8'(TAPS / 2 - 1);
    localparam logic [7:0] H_HI = 8'(TAPS / 2 + NUM_PIXEL - 2);
    localparam logic [4:0] COL_LAST = 5'(NUM_PIXEL - 1);
    localparam logic [7:0] DRAIN_LAST = 8'(PIPE_LAT - 1);

    state_t state;
    logic [7:0] cnt;
    logic [4:0] col;
    logic [1:0] src;
    logic [1:0] next_src;
    logic [9:0] dq;
    logic dh;
    logic dv;
    logic [7:0] didx;
    logic in_rows;

    assign next_src = (src == SRC_A) ? SRC_B : SRC_C;
    assign load_in = row_valid & row_ready;

    // sequencer state, counters and registered control outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            col <= '0;
            src <= SRC_A;
            busy <= 1'b0;
            done <= 1'b0;
            row_ready <= 1'b0;
            mux_sel <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FILL;
                        cnt <= '0;
                        col <= '0;
                        src <= SRC_A;
                        busy <= 1'b1;
                        row_ready <= 1'b1;
                    end
                end
                FILL: begin
                    if (row_valid) begin
                        if (cnt == ROW_LAST) begin
                            state <= HORIZ;
                            cnt <= '0;
                            row_ready <= 1'b0;
                            mux_sel <= '0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                HORIZ: begin
                    if (cnt == ROW_LAST) begin
                        state <= VERT;
                        cnt <= '0;
                        mux_sel <= SEL_VERT_FLAG | {1'b0, SRC_A, 5'd0};
                    end else begin
                        cnt <= cnt + 8'd1;
                        mux_sel <= cnt + 8'd1;
                    end
                end
                VERT: begin
                    if (src == SRC_C && col == COL_LAST) begin
                        state <= DRAIN;
                        cnt <= '0;
                    end else if (col == COL_LAST) begin
                        col <= '0;
                        src <= next_src;
                        mux_sel <= SEL_VERT_FLAG | {1'b0, next_src, 5'd0};
                    end else begin
                        col <= col + 5'd1;
                        mux_sel <= SEL_VERT_FLAG | {1'b0, src, col + 5'd1};
                    end
                end
                DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state <= DONE;
                        done <= 1'b1;
                        mux_sel <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done <= 1'b0;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // mux_sel already equals the row index in HORIZ and the vertical encoding in VERT
    subpel_issue_delay #(.DEPTH(PIPE_LAT), .W(10)) u_delay (
        .clk(clk),
        .rst(rst),
        .d({state == HORIZ, state == VERT, mux_sel}),
        .q(dq)
    );

    assign dh = dq[9];
    assign dv = dq[8];
    assign didx = dq[7:0];
    assign in_rows = didx >= H_LO && didx <= H_HI;
    assign load_L = dh;
    assign load_out = dv | (dh & in_rows);
    assign out_idx = dv ? didx : (dh & in_rows) ? didx - H_LO : 8'h00;

`ifdef SUBPEL_PERF_CNT_EN
    // saturating count of FILL cycles spent waiting on upstream rows
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start))
            stall_cnt <= '0;
        else if (state == FILL && !row_valid && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule
